// File: rtl/mem_arbiter_pkg.sv
// Shared bus definitions for the two-port memory arbiter: width defaults, port indices and
// the response tag that routes read data back to its requester.
package mem_arbiter_pkg;

   localparam int unsigned ADDR_W_DEF   = 8;
   localparam int unsigned DATA_W_DEF   = 8;
   localparam int unsigned LOCK_MAX_DEF = 3;

   localparam int unsigned PORT_CPU = 0;
   localparam int unsigned PORT_DBG = 1;

   typedef enum logic {
      TagCpu = 1'b0,
      TagDbg = 1'b1
   } respTag_e;

   function automatic respTag_e portTag(logic [1:0] grant);
      return grant[PORT_DBG] ? TagDbg : TagCpu;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with lastGrant history. Defining MEM_ARBITER_LOCK_EN adds
// bounded grant locking; without it the lock inputs are ignored.
module rr_arbiter2
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic [1:0] valid,
   input  logic [1:0] lock,
   output logic [1:0] grant
);

   logic       lastGrantQ, lastGrantD;
   logic [1:0] rrGrant;
   logic [1:0] grantRaw;
   logic       accept;

   always_comb begin
      rrGrant = 2'b00;
      unique case (valid)
         2'b01:   rrGrant = 2'b01;
         2'b10:   rrGrant = 2'b10;
         2'b11:   rrGrant = lastGrantQ ? 2'b01 : 2'b10;
         default: rrGrant = 2'b00;
      endcase
   end

`ifdef MEM_ARBITER_LOCK_EN
   localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

   logic             ownerValidQ, ownerValidD;
   logic             ownerQ, ownerD;
   logic [CNT_W-1:0] lockCntQ, lockCntD;
   logic             acceptPort;

   // An owner blocks the other port even while it is momentarily idle.
   always_comb begin
      grantRaw = rrGrant;
      if (ownerValidQ) begin
         grantRaw = ownerQ ? {valid[1], 1'b0} : {1'b0, valid[0]};
      end
   end

   assign acceptPort = grant[1];

   // lockCntQ is 0 whenever there is no owner, so a fresh lock starts counting at 1.
   always_comb begin
      ownerValidD = ownerValidQ;
      ownerD      = ownerQ;
      lockCntD    = lockCntQ;
      if (accept) begin
         if (lock[acceptPort] && (32'(lockCntQ) + 32'd1 < LOCK_MAX)) begin
            ownerValidD = 1'b1;
            ownerD      = acceptPort;
            lockCntD    = lockCntQ + CNT_W'(1);
         end else begin
            ownerValidD = 1'b0;
            ownerD      = 1'b0;
            lockCntD    = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         ownerValidQ <= 1'b0;
         ownerQ      <= 1'b0;
         lockCntQ    <= '0;
      end else begin
         ownerValidQ <= ownerValidD;
         ownerQ      <= ownerD;
         lockCntQ    <= lockCntD;
      end
   end
`else
   logic unusedLock;
   assign unusedLock = ^lock;
   assign grantRaw   = rrGrant;
`endif

   // Reset forces every grant low immediately, not just at the next edge.
   assign grant  = resetN ? grantRaw : 2'b00;
   assign accept = |grant;

   assign lastGrantD = accept ? grant[1] : lastGrantQ;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         lastGrantQ <= 1'b1;
      end else begin
         lastGrantQ <= lastGrantD;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the CPU port and a debug/DMA port: one access per
// cycle, read data tagged back one cycle later. MEM_ARBITER_LOCK_EN enables grant locking.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
   input  logic              clk,
   input  logic              resetN,

   input  logic              req0Valid,
   output logic              req0Ready,
   input  logic [ADDR_W-1:0] req0Addr,
   input  logic              req0Write,
   input  logic [DATA_W-1:0] req0Data,
   input  logic              req0Lock,
   output logic              resp0Valid,
   output logic [DATA_W-1:0] resp0Data,

   input  logic              req1Valid,
   output logic              req1Ready,
   input  logic [ADDR_W-1:0] req1Addr,
   input  logic              req1Write,
   input  logic [DATA_W-1:0] req1Data,
   input  logic              req1Lock,
   output logic              resp1Valid,
   output logic [DATA_W-1:0] resp1Data,

   output logic [ADDR_W-1:0] memAddr,
   output logic              memStrobe,
   output logic              memWrite,
   output logic [DATA_W-1:0] memDataWrite,
   input  logic [DATA_W-1:0] memDataRead
);

   logic [1:0] grant;
   logic       respValidQ;
   respTag_e   respTagQ;

   rr_arbiter2 #(
      .LOCK_MAX(LOCK_MAX)
   ) uArb (
      .clk   (clk),
      .resetN(resetN),
      .valid ({req1Valid, req0Valid}),
      .lock  ({req1Lock, req0Lock}),
      .grant (grant)
   );

   assign req0Ready = grant[PORT_CPU];
   assign req1Ready = grant[PORT_DBG];

   always_comb begin
      memStrobe    = 1'b0;
      memWrite     = 1'b0;
      memAddr      = '0;
      memDataWrite = '0;
      unique case (grant)
         2'b01: begin
            memStrobe    = 1'b1;
            memWrite     = req0Write;
            memAddr      = req0Addr;
            memDataWrite = req0Data;
         end
         2'b10: begin
            memStrobe    = 1'b1;
            memWrite     = req1Write;
            memAddr      = req1Addr;
            memDataWrite = req1Data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         respValidQ <= 1'b0;
         respTagQ   <= TagCpu;
      end else begin
         respValidQ <= memStrobe & ~memWrite;
         respTagQ   <= portTag(grant);
      end
   end

   assign resp0Valid = respValidQ & (respTagQ == TagCpu);
   assign resp1Valid = respValidQ & (respTagQ == TagDbg);
   assign resp0Data  = resp0Valid ? memDataRead : '0;
   assign resp1Data  = resp1Valid ? memDataRead : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level reference model, plus directed
// scenarios with literal expectations. Lock scenarios build only with MEM_ARBITER_LOCK_EN.
module tb_mem_arbiter;

   localparam int LOCK_MAX = 3;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       req0Valid, req0Ready, req0Write, req0Lock, resp0Valid;
   logic [7:0] req0Addr, req0Data, resp0Data;
   logic       req1Valid, req1Ready, req1Write, req1Lock, resp1Valid;
   logic [7:0] req1Addr, req1Data, resp1Data;
   logic [7:0] memAddr, memDataWrite;
   logic [7:0] memDataRead = 8'h00;
   logic       memStrobe, memWrite;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_W  (8),
      .DATA_W  (8),
      .LOCK_MAX(LOCK_MAX)
   ) dut (
      .clk         (clk),
      .resetN      (resetN),
      .req0Valid   (req0Valid),
      .req0Ready   (req0Ready),
      .req0Addr    (req0Addr),
      .req0Write   (req0Write),
      .req0Data    (req0Data),
      .req0Lock    (req0Lock),
      .resp0Valid  (resp0Valid),
      .resp0Data   (resp0Data),
      .req1Valid   (req1Valid),
      .req1Ready   (req1Ready),
      .req1Addr    (req1Addr),
      .req1Write   (req1Write),
      .req1Data    (req1Data),
      .req1Lock    (req1Lock),
      .resp1Valid  (resp1Valid),
      .resp1Data   (resp1Data),
      .memAddr     (memAddr),
      .memStrobe   (memStrobe),
      .memWrite    (memWrite),
      .memDataWrite(memDataWrite),
      .memDataRead (memDataRead)
   );

   // Memory device: registered read port.
   logic [7:0] mem [256];
   always @(posedge clk) begin
      if (memStrobe) begin
         if (memWrite) mem[memAddr] <= memDataWrite;
         else memDataRead <= mem[memAddr];
      end
   end

   int nChecks = 0;
   int nErrors = 0;
   bit checkEn = 1'b0;

   // Reference model state
   logic [7:0] refMem [256];
   int         mLast, mOwner, mCount;
   bit         pendV;
   int         pendPort;
   logic [7:0] pendData;
   bit         acc0, acc1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic resetModel();
      mLast  = 1;
      mOwner = -1;
      mCount = 0;
      pendV  = 1'b0;
      acc0   = 1'b0;
      acc1   = 1'b0;
   endtask

   function automatic int modelGrant(bit v0, bit v1);
      if (mOwner >= 0) return ((mOwner == 0) ? v0 : v1) ? mOwner : -1;
      if (v0 && v1) return 1 - mLast;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   // Compare process: outputs vs model, then advance the model by one cycle.
   always @(negedge clk) begin
      int         g;
      bit         w, lk;
      logic [7:0] a, d;
      if (checkEn && resetN) begin
         g = modelGrant(req0Valid, req1Valid);
         chk("req0Ready", req0Ready, g == 0);
         chk("req1Ready", req1Ready, g == 1);
         chk("memStrobe", memStrobe, g >= 0);
         chk("resp0Valid", resp0Valid, pendV && pendPort == 0);
         chk("resp1Valid", resp1Valid, pendV && pendPort == 1);
         chk("resp0Data", resp0Data, (pendV && pendPort == 0) ? pendData : 8'h00);
         chk("resp1Data", resp1Data, (pendV && pendPort == 1) ? pendData : 8'h00);
         if (g < 0) begin
            chk("memAddrIdle", memAddr, 0);
            chk("memWriteIdle", memWrite, 0);
            pendV = 1'b0;
         end else begin
            a  = (g == 0) ? req0Addr : req1Addr;
            w  = (g == 0) ? req0Write : req1Write;
            d  = (g == 0) ? req0Data : req1Data;
            lk = (g == 0) ? req0Lock : req1Lock;
            chk("memAddr", memAddr, a);
            chk("memWrite", memWrite, w);
            if (w) chk("memDataWrite", memDataWrite, d);
            pendV    = !w;
            pendPort = g;
            pendData = refMem[a];
            if (w) refMem[a] = d;
            mLast = g;
`ifdef MEM_ARBITER_LOCK_EN
            if (!lk) begin
               mOwner = -1;
               mCount = 0;
            end else begin
               mCount++;
               if (mCount >= LOCK_MAX) begin
                  mOwner = -1;
                  mCount = 0;
               end else mOwner = g;
            end
`else
            lk = 1'b0;
`endif
         end
         acc0 = req0Valid && req0Ready;
         acc1 = req1Valid && req1Ready;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      req0Valid = 0; req0Addr = 0; req0Write = 0; req0Data = 0; req0Lock = 0;
      req1Valid = 0; req1Addr = 0; req1Write = 0; req1Data = 0; req1Lock = 0;
   endtask

   task automatic doReset();
      checkEn = 1'b0;
      resetN  = 1'b0;
      idleInputs();
      resetModel();
      repeat (2) @(posedge clk);
      #1;
      resetN  = 1'b1;
      checkEn = 1'b1;
   endtask

   function automatic logic [7:0] pickAddr();
      return ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
   endfunction

   task automatic newReq0();
      req0Valid = ($urandom_range(0, 3) != 0);
      req0Addr  = pickAddr();
      req0Write = ($urandom_range(0, 2) == 0);
      req0Data  = 8'($urandom);
      req0Lock  = ($urandom_range(0, 3) == 0);
   endtask

   task automatic newReq1();
      req1Valid = ($urandom_range(0, 3) != 0);
      req1Addr  = pickAddr();
      req1Write = ($urandom_range(0, 2) == 0);
      req1Data  = 8'($urandom);
      req1Lock  = ($urandom_range(0, 3) == 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]    = 8'($urandom);
         refMem[i] = mem[i];
      end
      mem[8'h10]    = 8'hA5;
      refMem[8'h10] = 8'hA5;
      idleInputs();
      resetModel();

      // Held in reset with both ports requesting: nothing may be granted.
      req0Valid = 1; req1Valid = 1; req0Addr = 8'h33;
      #2;
      chk("rstReady0", req0Ready, 0);
      chk("rstReady1", req1Ready, 0);
      chk("rstStrobe", memStrobe, 0);
      chk("rstAddr", memAddr, 0);
      chk("rstResp0", resp0Valid, 0);
      repeat (2) @(posedge clk);
      #1;
      idleInputs();
      resetN  = 1'b1;
      checkEn = 1'b1;

      // Single port 0 read of 0x10.
      req0Valid = 1; req0Addr = 8'h10;
      @(negedge clk);
      chk("t1Ready0", req0Ready, 1);
      chk("t1Strobe", memStrobe, 1);
      chk("t1Addr", memAddr, 8'h10);
      tick();
      req0Valid = 0;
      @(negedge clk);
      chk("t1Resp0Valid", resp0Valid, 1);
      chk("t1Resp0Data", resp0Data, 8'hA5);
      chk("t1Resp1Valid", resp1Valid, 0);
      tick();

      // Both ports streaming reads: grants alternate starting with port 0.
      doReset();
      req0Valid = 1; req0Addr = 8'h00;
      req1Valid = 1; req1Addr = 8'h80;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t2AltGrant0", req0Ready, (i % 2) == 0);
         chk("t2AltGrant1", req1Ready, (i % 2) == 1);
         chk("t2NoIdle", memStrobe, 1);
         tick();
         if (acc0) req0Addr = req0Addr + 8'd1;
         if (acc1) req1Addr = req1Addr + 8'd1;
      end
      idleInputs();
      tick();

      // Write from port 1 immediately followed by read from port 0.
      req1Valid = 1; req1Write = 1; req1Addr = 8'h20; req1Data = 8'h3C;
      @(negedge clk);
      chk("t3WrReady", req1Ready, 1);
      chk("t3WrEn", memWrite, 1);
      tick();
      idleInputs();
      req0Valid = 1; req0Addr = 8'h20;
      @(negedge clk);
      chk("t3NoWrResp", resp1Valid, 0);
      chk("t3RdReady", req0Ready, 1);
      tick();
      idleInputs();
      @(negedge clk);
      chk("t3RdValid", resp0Valid, 1);
      chk("t3RdData", resp0Data, 8'h3C);
      tick();

      // Reset in the cycle after a read accept swallows the response.
      req0Valid = 1; req0Addr = 8'h10;
      @(negedge clk);
      chk("t4Accept", req0Ready, 1);
      @(posedge clk);
      #2;
      checkEn = 1'b0;
      resetN  = 1'b0;
      req1Valid = 1;
      #1;
      chk("t4Resp0Valid", resp0Valid, 0);
      chk("t4Resp0Data", resp0Data, 0);
      chk("t4Ready0", req0Ready, 0);
      chk("t4Ready1", req1Ready, 0);
      chk("t4Strobe", memStrobe, 0);
      chk("t4Addr", memAddr, 0);
      doReset();

`ifdef MEM_ARBITER_LOCK_EN
      begin
         int expSeq[5] = '{0, 0, 0, 1, 0};
         int n0 = 0;
         int who;
         req0Valid = 1; req0Lock = 1; req0Addr = 8'h40;
         req1Valid = 1; req1Addr = 8'h90;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            who = req0Ready ? 0 : (req1Ready ? 1 : -1);
            chk("t5LockSeq", who, expSeq[i]);
            tick();
            if (acc0) begin
               n0++;
               req0Addr = req0Addr + 8'd1;
               if (n0 == 4) req0Valid = 0;
            end
            if (acc1) req1Addr = req1Addr + 8'd1;
         end
      end
      doReset();

      req0Valid = 1; req0Lock = 1; req0Addr = 8'h50;
      req1Valid = 1; req1Addr = 8'hA0;
      @(negedge clk);
      chk("t6LockAccept", req0Ready, 1);
      tick();
      req0Valid = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("t6Blocked", req1Ready, 0);
         tick();
      end
      req0Valid = 1; req0Lock = 0; req0Addr = 8'h51;
      @(negedge clk);
      chk("t6Unlock0", req0Ready, 1);
      chk("t6Unlock1", req1Ready, 0);
      tick();
      req0Valid = 0;
      @(negedge clk);
      chk("t6Released", req1Ready, 1);
      tick();
      doReset();
`endif

      // Randomized traffic; pending requests are held until accepted.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc == 2000) doReset();
         if (!(req0Valid && !acc0)) newReq0();
         if (!(req1Valid && !acc1)) newReq1();
         tick();
      end
      idleInputs();
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
